// File: rtl/SB_codex_pkg.sv
// Sideband message codes and SBINIT state encoding shared by the LTSM blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package SB_codex_pkg;

   localparam int SB_MSG_CODE_W = 8;

   localparam logic [SB_MSG_CODE_W-1:0] MSG_SBINIT_OOR       = 8'h91;
   localparam logic [SB_MSG_CODE_W-1:0] MSG_SBINIT_DONE_REQ  = 8'h95;
   localparam logic [SB_MSG_CODE_W-1:0] MSG_SBINIT_DONE_RESP = 8'h9A;

   typedef enum logic [2:0] {
      IDLE,
      PAT_TX,
      PAT_FINISH,
      OOR_SEND,
      OOR_WAIT,
      DREQ_SEND,
      DONE_WAIT,
      DONE
   } sbinit_state_t;

endpackage

// File: rtl/sb_pattern_detect.sv
// Detects the partner SB pattern: counts consecutive samples where RX clk and data both toggle.
// Latency: pat_det rises at the edge that samples the DETECT_LEN-th consecutive toggling pair.
// Backpressure: none; samples every cycle while sample is high, clear wipes all state.
module sb_pattern_detect #(
   parameter int DETECT_LEN = 64
) (
   input  logic clk_100MHz,
   input  logic reset,
   input  logic clear,
   input  logic sample,
   input  logic rx_clk,
   input  logic rx_data,
   output logic pat_det
);

   localparam int RUN_W = $clog2(DETECT_LEN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DETECT_LEN);

   logic [RUN_W-1:0] run_cnt;
   logic             prev_clk;
   logic             prev_data;

   // Run counter of toggling samples; pat_det is sticky until cleared.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         run_cnt   <= '0;
         prev_clk  <= 1'b0;
         prev_data <= 1'b0;
         pat_det   <= 1'b0;
      end else if (clear) begin
         run_cnt   <= '0;
         prev_clk  <= 1'b0;
         prev_data <= 1'b0;
         pat_det   <= 1'b0;
      end else if (sample) begin
         prev_clk  <= rx_clk;
         prev_data <= rx_data;
         if ((rx_data != prev_data) && (rx_clk != prev_clk)) begin
            if (run_cnt != RUN_MAX) begin
               run_cnt <= run_cnt + 1'b1;
            end
            if (run_cnt == RUN_MAX - 1'b1) begin
               pat_det <= 1'b1;
            end
         end else begin
            run_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ltsm_sbinit.sv
// SBINIT engine: SB pattern TX/detect, then OUT_OF_RESET / DONE_REQ / DONE_RESP exchange; done_o ends SBINIT.
// Latency: IDLE->PAT_TX one cycle after enable_i; each message held until its tx_msg_ack_i, dropped next cycle.
// Backpressure: tx_msg_valid_o waits indefinitely on tx_msg_ack_i; optional SBINIT_ITER_CNT_EN adds pat_iter_cnt_o.
module ltsm_sbinit
   import SB_codex_pkg::*;
#(
   parameter int PAT_ON_CYC  = 64,
   parameter int PAT_OFF_CYC = 32,
   parameter int DETECT_LEN  = 64,
   parameter int EXTRA_ITER  = 4
) (
   input  logic                     clk_100MHz,
   input  logic                     reset,
   input  logic                     enable_i,
   output logic                     SB_clkPin_TX_o,
   output logic                     SB_dataPin_TX_o,
   input  logic                     SB_clkPin_RX_i,
   input  logic                     SB_dataPin_RX_i,
   output logic [SB_MSG_CODE_W-1:0] tx_msg_o,
   output logic                     tx_msg_valid_o,
   input  logic                     tx_msg_ack_i,
   input  logic [SB_MSG_CODE_W-1:0] rx_msg_i,
   input  logic                     rx_msg_valid_i,
   output logic                     done_o
`ifdef SBINIT_ITER_CNT_EN
   ,output logic [7:0]              pat_iter_cnt_o
`endif
);

   localparam int PAT_PER = PAT_ON_CYC + PAT_OFF_CYC;
   localparam int CNT_W   = $clog2(PAT_PER);
   localparam int WRAP_W  = $clog2(EXTRA_ITER + 1);
   localparam logic [CNT_W-1:0]  PAT_LAST  = CNT_W'(PAT_PER - 1);
   localparam logic [CNT_W-1:0]  PAT_ON    = CNT_W'(PAT_ON_CYC);
   localparam logic [WRAP_W-1:0] WRAP_LAST = WRAP_W'(EXTRA_ITER);

   sbinit_state_t            state;
   logic [CNT_W-1:0]         pat_cnt;
   logic [WRAP_W-1:0]        wrap_cnt;
   logic                     rx_oor;
   logic                     rx_dreq;
   logic                     rx_dresp;
   logic                     resp_sent;
   logic [SB_MSG_CODE_W-1:0] tx_msg;
   logic                     tx_msg_valid;
   logic                     pat_det;
   logic                     pat_active;
   logic                     pat_last;
   logic                     rx_capture;

   assign pat_active = (state == PAT_TX) || (state == PAT_FINISH);
   assign pat_last   = (pat_cnt == PAT_LAST);
   // Partner messages only count once our own pattern phase is winding down.
   assign rx_capture = rx_msg_valid_i && (state != IDLE) && (state != PAT_TX);

   sb_pattern_detect #(
      .DETECT_LEN (DETECT_LEN)
   ) u_det (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .clear      (state == IDLE),
      .sample     (pat_active),
      .rx_clk     (SB_clkPin_RX_i),
      .rx_data    (SB_dataPin_RX_i),
      .pat_det    (pat_det)
   );

   // Pins follow the phase counter: alternating clk/data in the on window, low in the gap.
   assign SB_dataPin_TX_o = pat_active && (pat_cnt < PAT_ON) && !pat_cnt[0];
   assign SB_clkPin_TX_o  = pat_active && (pat_cnt < PAT_ON) &&  pat_cnt[0];
   assign tx_msg_o        = tx_msg;
   assign tx_msg_valid_o  = tx_msg_valid;
   assign done_o          = (state == DONE);

   // Main SBINIT sequencer with registered message request and sticky RX flags.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         pat_cnt      <= '0;
         wrap_cnt     <= '0;
         rx_oor       <= 1'b0;
         rx_dreq      <= 1'b0;
         rx_dresp     <= 1'b0;
         resp_sent    <= 1'b0;
         tx_msg       <= '0;
         tx_msg_valid <= 1'b0;
      end else if (!enable_i) begin
         state        <= IDLE;
         pat_cnt      <= '0;
         wrap_cnt     <= '0;
         rx_oor       <= 1'b0;
         rx_dreq      <= 1'b0;
         rx_dresp     <= 1'b0;
         resp_sent    <= 1'b0;
         tx_msg       <= '0;
         tx_msg_valid <= 1'b0;
      end else begin
         if (rx_capture) begin
            case (rx_msg_i)
               MSG_SBINIT_OOR:       rx_oor   <= 1'b1;
               MSG_SBINIT_DONE_REQ:  rx_dreq  <= 1'b1;
               MSG_SBINIT_DONE_RESP: rx_dresp <= 1'b1;
               default: ;
            endcase
         end
         case (state)
            IDLE: begin
               state    <= PAT_TX;
               pat_cnt  <= '0;
               wrap_cnt <= '0;
            end
            PAT_TX: begin
               pat_cnt <= pat_last ? '0 : pat_cnt + 1'b1;
               if (pat_det) begin
                  state <= PAT_FINISH;
               end
            end
            PAT_FINISH: begin
               pat_cnt <= pat_last ? '0 : pat_cnt + 1'b1;
               if (pat_last) begin
                  // First wrap closes the iteration in flight; EXTRA_ITER more follow it.
                  if (wrap_cnt == WRAP_LAST) begin
                     state        <= OOR_SEND;
                     tx_msg       <= MSG_SBINIT_OOR;
                     tx_msg_valid <= 1'b1;
                  end else begin
                     wrap_cnt <= wrap_cnt + 1'b1;
                  end
               end
            end
            OOR_SEND: begin
               if (tx_msg_ack_i) begin
                  state        <= OOR_WAIT;
                  tx_msg       <= '0;
                  tx_msg_valid <= 1'b0;
               end
            end
            OOR_WAIT: begin
               if (rx_oor) begin
                  state        <= DREQ_SEND;
                  tx_msg       <= MSG_SBINIT_DONE_REQ;
                  tx_msg_valid <= 1'b1;
               end
            end
            DREQ_SEND: begin
               if (tx_msg_ack_i) begin
                  state        <= DONE_WAIT;
                  tx_msg       <= '0;
                  tx_msg_valid <= 1'b0;
               end
            end
            DONE_WAIT: begin
               if (tx_msg_valid) begin
                  if (tx_msg_ack_i) begin
                     tx_msg       <= '0;
                     tx_msg_valid <= 1'b0;
                     resp_sent    <= 1'b1;
                  end
               end else if (resp_sent && rx_dresp) begin
                  state <= DONE;
               end else if (rx_dreq && !resp_sent) begin
                  tx_msg       <= MSG_SBINIT_DONE_RESP;
                  tx_msg_valid <= 1'b1;
               end
            end
            DONE: ;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SBINIT_ITER_CNT_EN
   logic [7:0] iter_cnt;

   // Count completed TX iterations, saturating, cleared whenever the engine is idle.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         iter_cnt <= 8'd0;
      end else if (!enable_i || (state == IDLE)) begin
         iter_cnt <= 8'd0;
      end else if (pat_active && pat_last && (iter_cnt != 8'hFF)) begin
         iter_cnt <= iter_cnt + 8'd1;
      end
   end

   assign pat_iter_cnt_o = iter_cnt;
`endif

endmodule

// File: tb/tb_ltsm_sbinit.sv
// Bench for ltsm_sbinit: plays the SB partner, predicts pin pattern and message order from first principles.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: acks are delayed by the bench to exercise held requests.
module tb_ltsm_sbinit;
   import SB_codex_pkg::*;

   localparam int PER   = 96;
   localparam int ON    = 64;
   localparam int DLEN  = 64;
   localparam int EXTRA = 4;

   logic       clk_100MHz = 1'b0;
   logic       reset;
   logic       enable;
   logic       sb_clk_tx, sb_data_tx;
   logic       sb_clk_rx, sb_data_rx;
   logic [7:0] tx_msg, rx_msg;
   logic       tx_valid, tx_ack, rx_valid, done;
`ifdef SBINIT_ITER_CNT_EN
   logic [7:0] iter_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   ltsm_sbinit dut (
      .clk_100MHz      (clk_100MHz),
      .reset           (reset),
      .enable_i        (enable),
      .SB_clkPin_TX_o  (sb_clk_tx),
      .SB_dataPin_TX_o (sb_data_tx),
      .SB_clkPin_RX_i  (sb_clk_rx),
      .SB_dataPin_RX_i (sb_data_rx),
      .tx_msg_o        (tx_msg),
      .tx_msg_valid_o  (tx_valid),
      .tx_msg_ack_i    (tx_ack),
      .rx_msg_i        (rx_msg),
      .rx_msg_valid_i  (rx_valid),
      .done_o          (done)
`ifdef SBINIT_ITER_CNT_EN
      ,.pat_iter_cnt_o (iter_cnt)
`endif
   );

   always #5 clk_100MHz = ~clk_100MHz;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected {clk,data} for pattern cycle t counted from the first PAT_TX cycle.
   function automatic logic [1:0] exp_pins(input int t);
      int ph;
      ph = t % PER;
      if (ph < ON) return {ph[0], ~ph[0]};
      return 2'b00;
   endfunction

   task automatic send_rx(input logic [7:0] code);
      rx_msg   = code;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      rx_msg   = 8'h00;
   endtask

   task automatic wait_valid(input string tag, input logic [7:0] code);
      int k;
      k = 0;
      while (!tx_valid && k < 40) begin
         tick();
         k++;
      end
      chk({tag, " valid"}, {31'd0, tx_valid}, 32'd1);
      chk({tag, " code"}, {24'd0, tx_msg}, {24'd0, code});
   endtask

   // Hold ack low for dly cycles, pulse it, then expect valid to fall.
   task automatic ack_msg(input string tag, input logic [7:0] code, input int dly);
      for (int i = 0; i < dly; i++) begin
         chk({tag, " hold"}, {23'd0, tx_valid, tx_msg}, {23'd0, 1'b1, code});
         tick();
      end
      tx_ack = 1'b1;
      chk({tag, " at ack"}, {23'd0, tx_valid, tx_msg}, {23'd0, 1'b1, code});
      tick();
      tx_ack = 1'b0;
      chk({tag, " drop"}, {23'd0, tx_valid, tx_msg}, 32'd0);
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (!done && k < 40) begin
         tick();
         k++;
      end
      chk({tag, " done"}, {31'd0, done}, 32'd1);
      chk({tag, " done outs"}, {21'd0, sb_clk_tx, sb_data_tx, tx_valid, tx_msg}, 32'd0);
   endtask

   task automatic chk_idle(input string tag);
      chk(tag, {20'd0, sb_clk_tx, sb_data_tx, tx_valid, done, tx_msg}, 32'd0);
   endtask

   // Partner toggles both RX pins every cycle except one random glitch cycle g.
   task automatic do_pattern(input string tag, input int g);
      bit seq [0:575];
      bit v, prev;
      int run, td, last;
      v = 1'b0;
      for (int t = 0; t < 576; t++) begin
         if (t != g) v = ~v;
         seq[t] = v;
      end
      prev = 1'b0; run = 0; td = -1;
      for (int t = 0; t < 576; t++) begin
         if (seq[t] != prev) begin
            if (run < DLEN) run++;
         end else begin
            run = 0;
         end
         prev = seq[t];
         if (run == DLEN && td < 0) td = t;
      end
      if (td < 0) td = 575;
      // pat_det visible the cycle after td; PAT_FINISH starts the cycle after that.
      last = ((td + 2) / PER + 1 + EXTRA) * PER - 1;
      if (last > 575) last = 575;
      for (int t = 0; t <= last; t++) begin
         sb_clk_rx  = seq[t];
         sb_data_rx = seq[t];
         chk({tag, " pins"}, {28'd0, sb_clk_tx, sb_data_tx, tx_valid, done},
             {28'd0, exp_pins(t), 2'b00});
         tick();
      end
      sb_clk_rx  = 1'b0;
      sb_data_rx = 1'b0;
`ifdef SBINIT_ITER_CNT_EN
      chk({tag, " iter cnt"}, {24'd0, iter_cnt}, (last + 1) / PER);
`endif
      chk({tag, " pins off"}, {30'd0, sb_clk_tx, sb_data_tx}, 32'd0);
      chk({tag, " oor req"}, {23'd0, tx_valid, tx_msg}, {23'd0, 1'b1, MSG_SBINIT_OOR});
   endtask

   initial begin
      reset      = 1'b1;
      enable     = 1'b0;
      sb_clk_rx  = 1'b0;
      sb_data_rx = 1'b0;
      tx_ack     = 1'b0;
      rx_msg     = 8'h00;
      rx_valid   = 1'b0;
      tick();
      tick();
      chk_idle("reset outs");
`ifdef SBINIT_ITER_CNT_EN
      chk("reset iter", {24'd0, iter_cnt}, 32'd0);
`endif
      reset = 1'b0;
      tick();
      chk_idle("idle after reset");

      // A: in-order exchange, 10-cycle ack delay on OOR, ignored ack/unknown code.
      enable = 1'b1;
      tick();
      do_pattern("A", int'($urandom_range(25, 0)));
      ack_msg("A oor", MSG_SBINIT_OOR, 10);
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      send_rx(8'h42);
      for (int i = 0; i < 3; i++) begin
         chk("A oor_wait quiet", {31'd0, tx_valid}, 32'd0);
         tick();
      end
      send_rx(MSG_SBINIT_OOR);
      wait_valid("A dreq", MSG_SBINIT_DONE_REQ);
      ack_msg("A dreq", MSG_SBINIT_DONE_REQ, int'($urandom_range(3, 0)));
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      chk("A no resp yet", {30'd0, tx_valid, done}, 32'd0);
      send_rx(MSG_SBINIT_DONE_REQ);
      wait_valid("A resp", MSG_SBINIT_DONE_RESP);
      ack_msg("A resp", MSG_SBINIT_DONE_RESP, int'($urandom_range(3, 0)));
      for (int i = 0; i < 3; i++) begin
         chk("A wait dresp", {31'd0, done}, 32'd0);
         tick();
      end
      send_rx(MSG_SBINIT_DONE_RESP);
      wait_done("A");
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("A done held", {31'd0, done}, 32'd1);
      end
      enable = 1'b0;
      tick();
      chk_idle("A disable");

      // B: partner DONE_REQ arrives before its OOR.
      enable = 1'b1;
      tick();
      do_pattern("B", int'($urandom_range(25, 0)));
      ack_msg("B oor", MSG_SBINIT_OOR, int'($urandom_range(3, 0)));
      send_rx(MSG_SBINIT_DONE_REQ);
      for (int i = 0; i < 4; i++) begin
         chk("B early dreq quiet", {31'd0, tx_valid}, 32'd0);
         tick();
      end
      send_rx(MSG_SBINIT_OOR);
      wait_valid("B dreq", MSG_SBINIT_DONE_REQ);
      ack_msg("B dreq", MSG_SBINIT_DONE_REQ, int'($urandom_range(3, 0)));
      wait_valid("B resp", MSG_SBINIT_DONE_RESP);
      ack_msg("B resp", MSG_SBINIT_DONE_RESP, int'($urandom_range(3, 0)));
      chk("B before dresp", {31'd0, done}, 32'd0);
      send_rx(MSG_SBINIT_DONE_RESP);
      wait_done("B");
      enable = 1'b0;
      tick();
      chk_idle("B disable");

      // C: abort while DONE_RESP is pending in DONE_WAIT.
      enable = 1'b1;
      tick();
      do_pattern("C", int'($urandom_range(25, 0)));
      ack_msg("C oor", MSG_SBINIT_OOR, int'($urandom_range(3, 0)));
      send_rx(MSG_SBINIT_OOR);
      wait_valid("C dreq", MSG_SBINIT_DONE_REQ);
      ack_msg("C dreq", MSG_SBINIT_DONE_REQ, 0);
      send_rx(MSG_SBINIT_DONE_REQ);
      wait_valid("C resp", MSG_SBINIT_DONE_RESP);
      enable = 1'b0;
      tick();
      chk_idle("C abort");

      // D: RX data stuck low, pattern must repeat past the normal exit point.
      enable = 1'b1;
      tick();
      for (int t = 0; t < 600; t++) begin
         sb_clk_rx  = t[0];
         sb_data_rx = 1'b0;
         chk("D stuck pins", {28'd0, sb_clk_tx, sb_data_tx, tx_valid, done},
             {28'd0, exp_pins(t), 2'b00});
         tick();
      end
      sb_clk_rx = 1'b0;
      enable    = 1'b0;
      tick();
      chk_idle("D disable");
      tick();

      // E: asynchronous reset in the middle of PAT_FINISH.
      enable = 1'b1;
      tick();
      for (int t = 0; t < 200; t++) begin
         sb_clk_rx  = ~t[0];
         sb_data_rx = ~t[0];
         tick();
      end
      chk("E in finish pins", {30'd0, sb_clk_tx, sb_data_tx}, {30'd0, exp_pins(200)});
      #2;
      reset = 1'b1;
      #1;
      chk_idle("E async reset");
`ifdef SBINIT_ITER_CNT_EN
      chk("E iter cleared", {24'd0, iter_cnt}, 32'd0);
`endif
      enable     = 1'b0;
      sb_clk_rx  = 1'b0;
      sb_data_rx = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      chk_idle("E after reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
